// File: rtl/uart_xcvr.sv
// rtl/uart_xcvr.sv - UART transmitter/receiver with runtime frame format
// Define UART_LOOPBACK_EN to add the loopback port (TX line fed to RX, tx_out held high).
module uart_xcvr #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(DATA_W)-1:0] cfg_len,
  input  logic                      cfg_par_en,
  input  logic                      cfg_par_odd,
  input  logic                      cfg_stop2,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_start,
  output logic                      tx_out,
  output logic                      tx_busy,
`ifdef UART_LOOPBACK_EN
  input  logic                      loopback,
`endif
  input  logic                      rx_in,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  output logic                      rx_par_err,
  output logic                      rx_frm_err
);

  localparam int CFGW = $clog2(DATA_W);
  localparam int LW   = CFGW + 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Frame length in bits: cfg_len+1, clamped to [5, DATA_W].
  function automatic logic [LW-1:0] eff_len(input logic [CFGW-1:0] c);
    int l;
    l = int'(c) + 1;
    if (l < 5) l = 5;
    if (l > DATA_W) l = DATA_W;
    return LW'(l);
  endfunction

  // Ones in the low l bit positions.
  function automatic logic [DATA_W-1:0] len_mask(input logic [LW-1:0] l);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  logic [LW-1:0]     cfg_len_eff;
  logic [DATA_W-1:0] tx_data_m;

  assign cfg_len_eff = eff_len(cfg_len);
  assign tx_data_m   = tx_data & len_mask(cfg_len_eff);

  // ---------------- transmitter ----------------
  state_t            tx_state, tx_state_n;
  logic [CW-1:0]     tx_cnt;
  logic [LW-1:0]     tx_idx;
  logic [LW-1:0]     tx_len;
  logic [DATA_W-1:0] tx_shift;
  logic              tx_par_en, tx_stop2, tx_par;
  logic              tx_line, tx_bit_end;

  assign tx_bit_end = (tx_cnt == CNT_LAST);
  assign tx_busy    = (tx_state != IDLE);

  // TX next state and line level; tx_idx counts data bits, then stop bits.
  always_comb begin
    tx_state_n = tx_state;
    tx_line    = 1'b1;
    case (tx_state)
      IDLE:   if (tx_start) tx_state_n = START;
      START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_state_n = DATA;
      end
      DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_end && tx_idx == tx_len - LEN_ONE)
          tx_state_n = tx_par_en ? PARITY : STOP;
      end
      PARITY: begin
        tx_line = tx_par;
        if (tx_bit_end) tx_state_n = STOP;
      end
      STOP:   if (tx_bit_end && (!tx_stop2 || tx_idx == LEN_ONE)) tx_state_n = IDLE;
      default: tx_state_n = IDLE;
    endcase
  end

  // TX state, bit timing and frame capture (payload and format frozen at start).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state  <= IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_len    <= '0;
      tx_shift  <= '0;
      tx_par_en <= 1'b0;
      tx_stop2  <= 1'b0;
      tx_par    <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      if (tx_state == IDLE) begin
        tx_cnt <= '0;
        tx_idx <= '0;
        if (tx_start) begin
          tx_len    <= cfg_len_eff;
          tx_shift  <= tx_data_m;
          tx_par_en <= cfg_par_en;
          tx_stop2  <= cfg_stop2;
          tx_par    <= (^tx_data_m) ^ cfg_par_odd;
        end
      end else begin
        tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_ONE;
        if (tx_bit_end) begin
          if (tx_state == DATA) tx_shift <= tx_shift >> 1;
          tx_idx <= (tx_state_n == tx_state) ? tx_idx + LEN_ONE : '0;
        end
      end
    end
  end

  // ---------------- line routing ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_line : rx_in;
  assign tx_out = loopback ? 1'b1 : tx_line;
`else
  assign rx_src = rx_in;
  assign tx_out = tx_line;
`endif

  // ---------------- receiver ----------------
  logic rx_meta, rx_s;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_s    <= rx_meta;
    end
  end

  state_t            rx_state, rx_state_n;
  logic [CW-1:0]     rx_cnt;
  logic [LW-1:0]     rx_idx;
  logic [LW-1:0]     rx_len;
  logic [DATA_W-1:0] rx_shift;
  logic              rx_par_en, rx_odd, rx_pbit;
  logic              rx_sample;

  // Half a bit into START, then one full bit period per sample after that.
  assign rx_sample = (rx_state == START) ? (rx_cnt == CNT_HALF) : (rx_cnt == CNT_LAST);

  // RX next state; a high level at the START re-sample is a false start.
  always_comb begin
    rx_state_n = rx_state;
    case (rx_state)
      IDLE:   if (!rx_s) rx_state_n = START;
      START:  if (rx_sample) rx_state_n = rx_s ? IDLE : DATA;
      DATA: begin
        if (rx_sample && rx_idx == rx_len - LEN_ONE)
          rx_state_n = rx_par_en ? PARITY : STOP;
      end
      PARITY: if (rx_sample) rx_state_n = STOP;
      STOP:   if (rx_sample) rx_state_n = IDLE;
      default: rx_state_n = IDLE;
    endcase
  end

  // RX sampling, frame assembly and result/flag update on the first stop bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state   <= IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_len     <= '0;
      rx_shift   <= '0;
      rx_par_en  <= 1'b0;
      rx_odd     <= 1'b0;
      rx_pbit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_par_err <= 1'b0;
      rx_frm_err <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_valid <= 1'b0;
      if (rx_state == IDLE) begin
        rx_cnt   <= '0;
        rx_idx   <= '0;
        rx_shift <= '0;
        if (!rx_s) begin
          rx_len    <= cfg_len_eff;
          rx_par_en <= cfg_par_en;
          rx_odd    <= cfg_par_odd;
        end
      end else begin
        rx_cnt <= rx_sample ? '0 : rx_cnt + CNT_ONE;
        if (rx_sample) begin
          case (rx_state)
            DATA: begin
              for (int i = 0; i < DATA_W; i++)
                if (i == int'(rx_idx)) rx_shift[i] <= rx_s;
              rx_idx <= rx_idx + LEN_ONE;
            end
            PARITY: rx_pbit <= rx_s;
            STOP: begin
              rx_valid   <= 1'b1;
              rx_data    <= rx_shift;
              rx_par_err <= rx_par_en & ((^rx_shift) ^ rx_pbit ^ rx_odd);
              rx_frm_err <= ~rx_s;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_xcvr.sv
// tb/tb_uart_xcvr.sv - scoreboard bench for uart_xcvr (16 clocks/bit, 8 data bits)
module tb_uart_xcvr;
  localparam int CPB = 16;
  localparam int DW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    cfg_len;
  logic          cfg_par_en, cfg_par_odd, cfg_stop2;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_out, tx_busy;
  logic          loopback;
  logic          rx_in;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_par_err, rx_frm_err;

  uart_xcvr #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_len(cfg_len), .cfg_par_en(cfg_par_en), .cfg_par_odd(cfg_par_odd), .cfg_stop2(cfg_stop2),
    .tx_data(tx_data), .tx_start(tx_start), .tx_out(tx_out), .tx_busy(tx_busy),
`ifdef UART_LOOPBACK_EN
    .loopback(loopback),
`endif
    .rx_in(rx_in), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_par_err(rx_par_err), .rx_frm_err(rx_frm_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rx_valid_cnt = 0;

  string         exp_tx_bits[$];
  int            exp_tx_len[$];
  logic [DW-1:0] exp_rx_data[$];
  logic          exp_rx_par[$];
  logic          exp_rx_frm[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // TX monitor: samples each bit mid-period and measures tx_busy length.
  initial begin : tx_mon
    int    k;
    string cap;
    string e;
    int    l;
    bit    in_frame;
    bit    aborted;
    k = 0; cap = ""; in_frame = 0; aborted = 0;
    forever begin
      @(negedge clk);
      if (!rst_n && in_frame) aborted = 1;
      if (tx_busy) begin
        if (!in_frame) begin
          in_frame = 1; k = 0; cap = ""; aborted = 0;
        end
        if (k % CPB == CPB / 2) begin
          if (tx_out) cap = {cap, "1"};
          else        cap = {cap, "0"};
        end
        k++;
      end else if (in_frame) begin
        in_frame = 0;
        if (!aborted) begin
          if (exp_tx_len.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected_frame: got bits %s with no expectation", cap);
          end else begin
            e = exp_tx_bits.pop_front();
            l = exp_tx_len.pop_front();
            total++;
            if (cap != e) begin
              bad++;
              $display("FAIL tx_bits: got %s expected %s", cap, e);
            end
            chk("tx_busy_len", k, l);
          end
        end
      end
    end
  end

  // RX monitor: pops one expected frame per rx_valid and checks it is a single-cycle pulse.
  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rx_valid_cnt++;
        if (exp_rx_data.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_unexpected_valid: got data 0x%0h with no expectation", rx_data);
        end else begin
          chk("rx_data", rx_data, exp_rx_data.pop_front());
          chk("rx_par_err", rx_par_err, exp_rx_par.pop_front());
          chk("rx_frm_err", rx_frm_err, exp_rx_frm.pop_front());
        end
        @(negedge clk);
        chk("rx_valid_pulse", rx_valid, 1'b0);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic wait_tx_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_busy && n < 600);
    if (tx_busy) chk("tx_idle_timeout", 1, 0);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic tx_send(input logic [DW-1:0] d, input bit mutate);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    if (mutate) begin
      cfg_len = 3'd7; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
      tx_data = 8'h00;
    end
    wait_tx_idle();
  endtask

  task automatic rx_send(input string bits, input bit mutate);
    for (int b = 0; b < bits.len(); b++) begin
      rx_in = (bits.getc(b) == 8'h31);
      repeat (CPB) @(posedge clk);
      #1;
      if (mutate && b == 0) begin
        cfg_len = 3'd7; cfg_par_en = 1'b1;
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic wait_rx();
    int n;
    n = 0;
    while (exp_rx_data.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_rx_data.size() != 0) chk("rx_valid_timeout", exp_rx_data.size(), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [DW-1:0] d, input logic p, input logic f);
    exp_rx_data.push_back(d);
    exp_rx_par.push_back(p);
    exp_rx_frm.push_back(f);
  endtask

  task automatic set_cfg(input logic [2:0] len, input logic pe, input logic po, input logic s2);
    cfg_len = len; cfg_par_en = pe; cfg_par_odd = po; cfg_stop2 = s2;
  endtask

  initial begin : main
    int cnt0;
    rst_n = 1'b0; rx_in = 1'b1; tx_start = 1'b0; tx_data = '0; loopback = 1'b0;
    set_cfg(3'd7, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_out", tx_out, 1'b1);
    chk("reset_tx_busy", tx_busy, 1'b0);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_par_err", rx_par_err, 1'b0);
    chk("reset_rx_frm_err", rx_frm_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 0xA5
    set_cfg(3'd7, 1'b0, 1'b0, 1'b0);
    exp_tx_bits.push_back("0101001011"); exp_tx_len.push_back(160);
    tx_send(8'hA5, 1'b0);

    // 7 bits, even parity, two stop bits, 0x55; cfg changed mid-frame
    set_cfg(3'd6, 1'b1, 1'b0, 1'b1);
    exp_tx_bits.push_back("01010101011"); exp_tx_len.push_back(176);
    tx_send(8'h55, 1'b1);

    // cfg_len=2 is treated as 5 bits, odd parity, 0xFF -> 11111 parity 0
    set_cfg(3'd2, 1'b1, 1'b1, 1'b0);
    exp_tx_bits.push_back("01111101"); exp_tx_len.push_back(128);
    tx_send(8'hFF, 1'b0);

    // back-to-back: tx_start held high, data changed mid-frame is ignored until idle
    set_cfg(3'd7, 1'b0, 1'b0, 1'b0);
    exp_tx_bits.push_back("0101001011"); exp_tx_len.push_back(160);
    exp_tx_bits.push_back("0111100001"); exp_tx_len.push_back(160);
    tx_data = 8'hA5; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h0F;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (tx_busy && n < 400);
    end
    chk("b2b_first_done", tx_busy, 1'b0);
    @(posedge clk); #1;
    tx_start = 1'b0;
    @(negedge clk);
    chk("b2b_no_gap_busy", tx_busy, 1'b1);
    chk("b2b_no_gap_start", tx_out, 1'b0);
    wait_tx_idle();

    // reset in the middle of a TX frame
    tx_data = 8'h00; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midtx_reset_tx_out", tx_out, 1'b1);
    chk("midtx_reset_tx_busy", tx_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // RX good frame: 8 bits odd parity 0x3C
    set_cfg(3'd7, 1'b1, 1'b1, 1'b0);
    push_rx(8'h3C, 1'b0, 1'b0);
    rx_send("00011110011", 1'b0);
    wait_rx();

    // RX wrong parity bit
    push_rx(8'h3C, 1'b1, 1'b0);
    rx_send("00011110001", 1'b0);
    wait_rx();

    // RX stop bit low, no parity
    set_cfg(3'd7, 1'b0, 1'b0, 1'b1);
    push_rx(8'hA5, 1'b0, 1'b1);
    rx_send("0101001010", 1'b0);
    wait_rx();

    // RX 5-bit frame 0x13, cfg changed after start bit must not matter
    set_cfg(3'd0, 1'b0, 1'b0, 1'b0);
    push_rx(8'h13, 1'b0, 1'b0);
    rx_send("0110011", 1'b1);
    wait_rx();

    // 3-cycle glitch: no frame, previous results held
    cnt0 = rx_valid_cnt;
    rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("glitch_no_valid", rx_valid_cnt, cnt0);
    chk("rx_data_hold", rx_data, 8'h13);
    chk("rx_frm_err_hold", rx_frm_err, 1'b0);

`ifdef UART_LOOPBACK_EN
    // loopback: RX sees TX internally, tx_out stays high
    set_cfg(3'd7, 1'b0, 1'b0, 1'b0);
    loopback = 1'b1;
    push_rx(8'h81, 1'b0, 1'b0);
    exp_tx_bits.push_back("1111111111"); exp_tx_len.push_back(160);
    tx_send(8'h81, 1'b0);
    wait_rx();
    loopback = 1'b0;
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("tx_expect_drained", exp_tx_len.size(), 0);
    chk("rx_expect_drained", exp_rx_data.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per bit period; legal range is 4 or more.
REQ-002 SHALL have parameter DATA_W, default 8: maximum number of data bits; legal range is 5 or more.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port cfg_len, input, $clog2(DATA_W) bits: data bits per frame = cfg_len+1; values giving fewer than 5 are treated as 5.
REQ-006 SHALL have port cfg_par_en, input, 1 bit: 1 = parity bit present.
REQ-007 SHALL have port cfg_par_odd, input, 1 bit: 1 = odd parity, 0 = even parity.
REQ-008 SHALL have port cfg_stop2, input, 1 bit: 1 = two stop bits on TX, 0 = one.
REQ-009 SHALL have port tx_data, input, DATA_W bits: frame payload, sent LSB first.
REQ-010 SHALL have port tx_start, input, 1 bit: start request.
REQ-011 SHALL have port tx_out, output, 1 bit: serial line out; idles high.
REQ-012 SHALL have port tx_busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port rx_in, input, 1 bit: asynchronous serial line in.
REQ-014 SHALL have port rx_data, output, DATA_W bits: last received payload; bits above the frame length are 0.
REQ-015 SHALL have port rx_valid, output, 1 bit: one-cycle pulse marking frame completion.
REQ-016 SHALL have port rx_par_err, output, 1 bit: parity mismatch flag for the last frame.
REQ-017 SHALL have port rx_frm_err, output, 1 bit: stop bit sampled low in the last frame.

Function
REQ-018 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; each bit lasts exactly CLKS_PER_BIT cycles; PARITY is skipped when cfg_par_en=0; STOP lasts 1 or 2 bit periods.
REQ-019 In IDLE with tx_start=1, TX SHALL capture tx_data and all cfg_* inputs, and SHALL raise tx_busy and drive tx_out=0 on the next cycle.
REQ-020 The parity bit SHALL be the XOR of all frame data bits for even parity and its inverse for odd parity.
REQ-021 tx_busy SHALL fall on the cycle after the last stop-bit period; tx_start in that same cycle SHALL begin a new frame with no idle gap.
REQ-022 tx_start while tx_busy=1 SHALL be ignored, and cfg_* changes mid-frame SHALL NOT affect the frame in flight (TX or RX).
REQ-023 rx_in SHALL pass through a 2-flop synchronizer whose flops reset to 1; the RX FSM SHALL use only the synchronized value.
REQ-024 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; a low synchronized level in IDLE SHALL enter START and latch the cfg_* inputs.
REQ-025 RX SHALL re-sample at CLKS_PER_BIT/2 cycles into START; if high (false start) it SHALL return to IDLE with no flags or pulse; otherwise it SHALL sample each following bit every CLKS_PER_BIT cycles.
REQ-026 RX SHALL check only the first stop bit, regardless of cfg_stop2; on that sample it SHALL pulse rx_valid, update rx_data, rx_par_err and rx_frm_err in the same cycle, and return to IDLE.
REQ-027 rx_valid SHALL assert even on error; rx_data and the flags SHALL hold until the next rx_valid; rx_par_err SHALL be 0 when parity is disabled.

Reset
REQ-028 While rst_n=0 at a clk edge (including mid-frame), both FSMs SHALL go to IDLE and all counters SHALL clear.
REQ-029 Reset values SHALL be: tx_out=1, tx_busy=0, rx_valid=0, rx_data=0, rx_par_err=0, rx_frm_err=0.

Configuration
REQ-030 With macro UART_LOOPBACK_EN defined, the module SHALL add input port loopback (1 bit); when loopback=1, the RX synchronizer input SHALL be the internal TX line and tx_out SHALL be held at 1.
REQ-031 With UART_LOOPBACK_EN undefined, the loopback port SHALL NOT exist and RX SHALL always use rx_in.

Verification (CLKS_PER_BIT=16, DATA_W=8)
REQ-032 Basic TX: 8N1, tx_data=0xA5 -> tx_out = 0,1,0,1,0,0,1,0,1,1, 16 cycles per bit; tx_busy high for exactly 160 cycles.
REQ-033 TX parity/stop: cfg_len=6 (7 bits), even parity, two stop bits, tx_data=0x55 -> data 1010101, parity 0, stop 1,1; tx_busy high for 176 cycles.
REQ-034 RX good frame: drive 8 data bits, odd parity, byte 0x3C -> one rx_valid pulse, rx_data=0x3C, rx_par_err=0, rx_frm_err=0.
REQ-035 RX errors: a frame with the wrong parity bit -> rx_par_err=1; a frame with stop bit=0 -> rx_frm_err=1 and rx_valid still pulses.
REQ-036 Glitch and reset: a 3-cycle low glitch on rx_in -> no rx_valid; rst_n=0 mid-TX -> tx_out=1 and tx_busy=0 on the next cycle.
REQ-037 Loopback: with UART_LOOPBACK_EN defined and loopback=1, send 0x81 at 8N1 -> rx_valid with rx_data=0x81 while tx_out stays 1.
